// File: rtl/fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : fifo_param
// Brief    : Parametrised single-clock circular-queue FIFO with occupancy
//            count, almost-full/almost-empty thresholds and error pulses.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_param #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 16,
   parameter int AF_LEVEL   = 14,
   parameter int AE_LEVEL   = 2,
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write,
   input  logic                  read,
   input  logic [DATA_WIDTH-1:0] d_in,
   output logic                  full,
   output logic                  empty,
   output logic [DATA_WIDTH-1:0] d_out,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [CW-1:0]         count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int            c_PW   = $clog2(DEPTH);
   localparam logic [c_PW-1:0] c_LAST = c_PW'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [c_PW-1:0]       r_wr_ptr;
   logic [c_PW-1:0]       r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic [DATA_WIDTH-1:0] r_d_out;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_rd_ok;
   logic                  w_wr_ok;
   logic [c_PW-1:0]       w_wr_ptr_nxt;
   logic [c_PW-1:0]       w_rd_ptr_nxt;

   // Flags decode from the registered count only, so no input reaches an output.
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);

   // A read at full frees a slot in the same edge, so a concurrent write is accepted.
   assign w_rd_ok = read & ~w_empty;
   assign w_wr_ok = write & (~w_full | w_rd_ok);

   assign w_wr_ptr_nxt = (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + c_PW'(1);
   assign w_rd_ptr_nxt = (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + c_PW'(1);

   always_ff @(posedge clk) begin
      if (!reset && w_wr_ok) begin
         r_mem[r_wr_ptr] <= d_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_d_out     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_ok) begin
            r_wr_ptr <= w_wr_ptr_nxt;
         end
         if (w_rd_ok) begin
            r_rd_ptr <= w_rd_ptr_nxt;
            r_d_out  <= r_mem[r_rd_ptr];
         end
         if (w_wr_ok && !w_rd_ok) begin
            r_count <= r_count + CW'(1);
         end else if (w_rd_ok && !w_wr_ok) begin
            r_count <= r_count - CW'(1);
         end
         r_overflow  <= write & ~w_wr_ok;
         r_underflow <= read & ~w_rd_ok;
      end
   end

   assign full         = w_full;
   assign empty        = w_empty;
   assign d_out        = r_d_out;
   assign almost_full  = (r_count >= CW'(AF_LEVEL));
   assign almost_empty = (r_count <= CW'(AE_LEVEL));
   assign count        = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_param
// Brief    : Bench for fifo_param: 16-deep default instance and 5-deep 8-bit
//            instance, vector table plus queue-model random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_param;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: defaults (16 x 16, AF 14, AE 2)
   logic        a_reset, a_write, a_read;
   logic [15:0] a_d_in, a_d_out;
   logic        a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
   logic [4:0]  a_count;

   // Instance B: 5 x 8, AF 4, AE 1
   logic        b_reset, b_write, b_read;
   logic [7:0]  b_d_in, b_d_out;
   logic        b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
   logic [2:0]  b_count;

   fifo_param dut_a (
      .clk(clk), .reset(a_reset), .write(a_write), .read(a_read), .d_in(a_d_in),
      .full(a_full), .empty(a_empty), .d_out(a_d_out), .almost_full(a_af),
      .almost_empty(a_ae), .count(a_count), .overflow(a_ovf), .underflow(a_unf)
   );

   fifo_param #(.DATA_WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut_b (
      .clk(clk), .reset(b_reset), .write(b_write), .read(b_read), .d_in(b_d_in),
      .full(b_full), .empty(b_empty), .d_out(b_d_out), .almost_full(b_af),
      .almost_empty(b_ae), .count(b_count), .overflow(b_ovf), .underflow(b_unf)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: a plain queue of words per instance
   int qa[$];
   int qb[$];
   int e_dout [2];
   bit e_ovf  [2];
   bit e_unf  [2];

   typedef struct {
      bit rst, wr, rd;
      int din;
      int cnt, dout;
      bit full, empty, af, ae, ovf, unf;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input bit rst, wr, rd, input int din, input int cnt, dout,
                      input bit full, empty, af, ae, ovf, unf);
      vec_t v;
      v.rst = rst; v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt; v.dout = dout;
      v.full = full; v.empty = empty; v.af = af; v.ae = ae; v.ovf = ovf; v.unf = unf;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step(input int id, input bit rst, wr, rd, input int din);
      int q[$];
      int dep;
      bit rok, wok;
      if (id == 0) begin q = qa; dep = 16; din = din & 16'hffff; end
      else         begin q = qb; dep = 5;  din = din & 8'hff;    end
      if (rst) begin
         q.delete();
         e_dout[id] = 0; e_ovf[id] = 0; e_unf[id] = 0;
      end else begin
         rok = rd && (q.size() > 0);
         wok = wr && ((q.size() < dep) || rok);
         if (rok) e_dout[id] = q.pop_front();
         if (wok) q.push_back(din);
         e_ovf[id] = wr && !wok;
         e_unf[id] = rd && !rok;
      end
      if (id == 0) qa = q; else qb = q;
   endtask

   task automatic drive(input int id, input bit rst, wr, rd, input int din);
      if (id == 0) begin a_reset = rst; a_write = wr; a_read = rd; a_d_in = 16'(din); end
      else         begin b_reset = rst; b_write = wr; b_read = rd; b_d_in = 8'(din);  end
      model_step(id, rst, wr, rd, din);
      @(posedge clk);
      #1;
      a_reset = 0; a_write = 0; a_read = 0;
      b_reset = 0; b_write = 0; b_read = 0;
   endtask

   task automatic check_model(input int id);
      int sz, dep, afl, ael;
      string p;
      if (id == 0) begin
         sz = qa.size(); dep = 16; afl = 14; ael = 2; p = "A";
         chk({p, " count"}, 32'(a_count), 32'(sz));
         chk({p, " d_out"}, 32'(a_d_out), 32'(e_dout[0]));
         chk({p, " full"},  32'(a_full),  32'(sz == dep));
         chk({p, " empty"}, 32'(a_empty), 32'(sz == 0));
         chk({p, " almost_full"},  32'(a_af), 32'(sz >= afl));
         chk({p, " almost_empty"}, 32'(a_ae), 32'(sz <= ael));
         chk({p, " overflow"},  32'(a_ovf), 32'(e_ovf[0]));
         chk({p, " underflow"}, 32'(a_unf), 32'(e_unf[0]));
      end else begin
         sz = qb.size(); dep = 5; afl = 4; ael = 1; p = "B";
         chk({p, " count"}, 32'(b_count), 32'(sz));
         chk({p, " d_out"}, 32'(b_d_out), 32'(e_dout[1]));
         chk({p, " full"},  32'(b_full),  32'(sz == dep));
         chk({p, " empty"}, 32'(b_empty), 32'(sz == 0));
         chk({p, " almost_full"},  32'(b_af), 32'(sz >= afl));
         chk({p, " almost_empty"}, 32'(b_ae), 32'(sz <= ael));
         chk({p, " overflow"},  32'(b_ovf), 32'(e_ovf[1]));
         chk({p, " underflow"}, 32'(b_unf), 32'(e_unf[1]));
      end
   endtask

   initial begin
      a_reset = 0; a_write = 0; a_read = 0; a_d_in = '0;
      b_reset = 0; b_write = 0; b_read = 0; b_d_in = '0;

      // Vector table for instance A, expectations written from the rules directly
      add(1,0,0,0,   0,0, 0,1,0,1,0,0);
      add(1,1,1,55,  0,0, 0,1,0,1,0,0);          // reset beats read/write
      add(0,0,1,0,   0,0, 0,1,0,1,0,1);
      add(0,0,1,0,   0,0, 0,1,0,1,0,1);
      for (int i = 1; i <= 16; i++)
         add(0,1,0,99+i, i,0, i==16,0,i>=14,i<=2,0,0);
      add(0,1,0,116, 16,0, 1,0,1,0,1,0);         // rejected 17th write
      for (int k = 1; k <= 16; k++)
         add(0,0,1,0, 16-k,99+k, 0,(16-k)==0,(16-k)>=14,(16-k)<=2,0,0);
      add(0,1,1,105, 1,115, 0,0,0,1,0,1);        // empty: read rejected, write taken
      for (int i = 0; i < 15; i++)
         add(0,1,0,200+i, 2+i,115, (2+i)==16,0,(2+i)>=14,(2+i)<=2,0,0);
      add(0,1,1,220, 16,105, 1,0,1,0,0,0);       // full: both accepted
      add(0,0,1,0,   15,200, 0,0,1,0,0,0);

      @(posedge clk); #1;
      foreach (tbl[n]) begin
         drive(0, tbl[n].rst, tbl[n].wr, tbl[n].rd, tbl[n].din);
         chk($sformatf("tbl%0d count", n), 32'(a_count), 32'(tbl[n].cnt));
         chk($sformatf("tbl%0d d_out", n), 32'(a_d_out), 32'(tbl[n].dout));
         chk($sformatf("tbl%0d full", n),  32'(a_full),  32'(tbl[n].full));
         chk($sformatf("tbl%0d empty", n), 32'(a_empty), 32'(tbl[n].empty));
         chk($sformatf("tbl%0d almost_full", n),  32'(a_af), 32'(tbl[n].af));
         chk($sformatf("tbl%0d almost_empty", n), 32'(a_ae), 32'(tbl[n].ae));
         chk($sformatf("tbl%0d overflow", n),  32'(a_ovf), 32'(tbl[n].ovf));
         chk($sformatf("tbl%0d underflow", n), 32'(a_unf), 32'(tbl[n].unf));
      end

      // Mid-operation reset discards contents, then normal traffic resumes
      for (int i = 1; i <= 3; i++) drive(0, 0, 1, 0, i);
      drive(0, 1, 0, 0, 0);
      check_model(0);
      chk("midreset empty", 32'(a_empty), 32'd1);
      chk("midreset d_out", 32'(a_d_out), 32'd0);
      drive(0, 0, 1, 0, 7);
      drive(0, 0, 0, 1, 0);
      check_model(0);
      chk("midreset readback", 32'(a_d_out), 32'd7);

      // Instance B: interleaved pairs force both pointers around the 5-entry ring
      drive(1, 1, 0, 0, 0);
      check_model(1);
      for (int i = 1; i <= 12; i++) begin
         drive(1, 0, 1, 0, i);
         check_model(1);
         drive(1, 0, 0, 1, 0);
         check_model(1);
         chk($sformatf("wrap d_out %0d", i), 32'(b_d_out), 32'(i));
      end

      // Random traffic: fill-biased then drain-biased, with rare resets
      for (int id = 0; id < 2; id++) begin
         for (int n = 0; n < 400; n++) begin
            int pw;
            bit r, w, rd;
            pw = (n % 200 < 100) ? 70 : 30;
            r  = ($urandom_range(0, 99) == 0);
            w  = ($urandom_range(0, 99) < pw);
            rd = ($urandom_range(0, 99) < (100 - pw));
            drive(id, r, w, rd, int'($urandom_range(0, 65535)));
            check_model(id);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
